// File: rtl/alu_cmd_driver_pkg.sv
// Shared definitions for the ALU command driver: opcode values, FSM state encodings
// and default widths.
package alu_cmd_driver_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int OUT_W_DEF  = 16;
   localparam int CMD_W_DEF  = 4;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_INC  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_DEC  = 4'h3;
   localparam logic [3:0] OP_MUL  = 4'h4;
   localparam logic [3:0] OP_DIV  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_INV  = 4'hA;
   localparam logic [3:0] OP_NAND = 4'hB;
   localparam logic [3:0] OP_NOR  = 4'hC;
   localparam logic [3:0] OP_XOR  = 4'hD;
   localparam logic [3:0] OP_XNOR = 4'hE;
   localparam logic [3:0] OP_BUF  = 4'hF;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_DRIVE   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

endpackage

// File: rtl/alu_cmd_driver_ref_model.sv
// Combinational reference of the 8-bit ALU: zero-extended operands, results mod 2^OUT_W.
// Logic ops are formed on DATA_W bits and then zero-extended.
module alu_cmd_driver_ref_model
   import alu_cmd_driver_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OUT_W  = OUT_W_DEF,
   parameter int CMD_W  = CMD_W_DEF
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [CMD_W-1:0]  i_cmd,
   output logic [OUT_W-1:0]  o_expect
);

   localparam int PAD = OUT_W - DATA_W;
   localparam logic [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};

   logic [OUT_W-1:0] w_a;
   logic [OUT_W-1:0] w_b;

   assign w_a = {{PAD{1'b0}}, i_a};
   assign w_b = {{PAD{1'b0}}, i_b};

   always_comb begin
      o_expect = '0;
      case (i_cmd)
         OP_ADD:  o_expect = w_a + w_b;
         OP_INC:  o_expect = w_a + ONE;
         OP_SUB:  o_expect = w_a - w_b;
         OP_DEC:  o_expect = w_a - ONE;
         OP_MUL:  o_expect = w_a * w_b;
         // Divide by zero has no defined ALU result; the checker never flags it.
         OP_DIV:  o_expect = (i_b == '0) ? '1 : w_a / w_b;
         OP_SHL:  o_expect = w_a << 1;
         OP_SHR:  o_expect = w_a >> 1;
         OP_AND:  o_expect = {{PAD{1'b0}}, i_a & i_b};
         OP_OR:   o_expect = {{PAD{1'b0}}, i_a | i_b};
         OP_INV:  o_expect = {{PAD{1'b0}}, ~i_a};
         OP_NAND: o_expect = {{PAD{1'b0}}, ~(i_a & i_b)};
         OP_NOR:  o_expect = {{PAD{1'b0}}, ~(i_a | i_b)};
         OP_XOR:  o_expect = {{PAD{1'b0}}, i_a ^ i_b};
         OP_XNOR: o_expect = {{PAD{1'b0}}, ~(i_a ^ i_b)};
         OP_BUF:  o_expect = w_a;
         default: o_expect = '0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_driver.sv
// Bus-side initiator for the 8-bit ALU: request in, drive pins, settle, capture, respond.
// Optional build macro ALU_CHECK_EN adds a reference-model compare that pulses o_chk_err.
//
// state   | meaning
// IDLE    | o_req_ready high, waiting for a request
// DRIVE   | operands and oe held, settle down-counter running
// CAPTURE | sample ALU result, drop oe
// RESP    | o_rsp_valid high until the consumer takes the result
module alu_cmd_driver
   import alu_cmd_driver_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int OUT_W      = OUT_W_DEF,
   parameter int CMD_W      = CMD_W_DEF,
   parameter int SETTLE_CYC = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [DATA_W-1:0] i_req_a,
   input  logic [DATA_W-1:0] i_req_b,
   input  logic [CMD_W-1:0]  i_req_cmd,
   output logic [DATA_W-1:0] o_alu_a,
   output logic [DATA_W-1:0] o_alu_b,
   output logic [CMD_W-1:0]  o_alu_cmd,
   output logic              o_alu_oe,
   input  logic [OUT_W-1:0]  i_alu_d,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [OUT_W-1:0]  o_rsp_data,
   output logic [CMD_W-1:0]  o_rsp_cmd,
   output logic [15:0]       o_txn_count,
   output logic              o_chk_err
);

   localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYC);

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [CMD_W-1:0]  r_alu_cmd;
   logic              r_alu_oe;
   logic              r_rsp_valid;
   logic [OUT_W-1:0]  r_rsp_data;
   logic [CMD_W-1:0]  r_rsp_cmd;
   logic [15:0]       r_txn_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_cmd   <= '0;
         r_alu_oe    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_cmd   <= '0;
         r_txn_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_req_valid) begin
                  r_alu_a   <= i_req_a;
                  r_alu_b   <= i_req_b;
                  r_alu_cmd <= i_req_cmd;
                  r_alu_oe  <= 1'b1;
                  r_cnt     <= LP_SETTLE;
                  r_state   <= ST_DRIVE;
               end
            end
            // Terminal count at zero: DRIVE spans SETTLE_CYC+1 cycles, giving
            // a full SETTLE_CYC of stable oe/operands after the pins update.
            ST_DRIVE: begin
               if (r_cnt == '0) r_state <= ST_CAPTURE;
               else             r_cnt   <= r_cnt - 4'd1;
            end
            ST_CAPTURE: begin
               r_rsp_data  <= i_alu_d;
               r_rsp_cmd   <= r_alu_cmd;
               r_alu_oe    <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_txn_count <= r_txn_count + 16'd1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_req_ready = (r_state == ST_IDLE);
   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_cmd   = r_alu_cmd;
   assign o_alu_oe    = r_alu_oe;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_cmd   = r_rsp_cmd;
   assign o_txn_count = r_txn_count;

`ifdef ALU_CHECK_EN
   logic [OUT_W-1:0] w_expect;
   logic             w_div_zero;
   logic             r_chk_err;

   alu_cmd_driver_ref_model #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W),
      .CMD_W  (CMD_W)
   ) u_ref (
      .i_a      (r_alu_a),
      .i_b      (r_alu_b),
      .i_cmd    (r_alu_cmd),
      .o_expect (w_expect)
   );

   assign w_div_zero = (r_alu_cmd == OP_DIV) && (r_alu_b == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_chk_err <= 1'b0;
      else          r_chk_err <= (r_state == ST_CAPTURE) && !w_div_zero && (i_alu_d != w_expect);
   end

   assign o_chk_err = r_chk_err;
`else
   assign o_chk_err = 1'b0;
`endif

endmodule
